// File: rtl/system_bus_interconnect.sv
// CPU-to-{mem, periph, unmapped} bus interconnect with in-order read tracking.
// Reads may only be outstanding to one target at a time, which keeps responses in acceptance order.
module system_bus_interconnect #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    output logic        system_bus_ready,
    input  logic [29:0] system_bus_addr,
    input  logic [31:0] system_bus_write_data,
    input  logic [3:0]  system_bus_byte_enable,
    input  logic        system_bus_write_req,
    input  logic        system_bus_read_req,
    output logic [31:0] system_bus_read_data,
    output logic        system_bus_read_data_valid,

    input  logic        mem_bus_ready,
    output logic [27:0] mem_bus_addr,
    output logic [31:0] mem_bus_write_data,
    output logic [3:0]  mem_bus_byte_enable,
    output logic        mem_bus_write_req,
    output logic        mem_bus_read_req,
    input  logic [31:0] mem_bus_read_data,
    input  logic        mem_bus_read_data_valid,

    input  logic        periph_bus_ready,
    output logic [27:0] periph_bus_addr,
    output logic [31:0] periph_bus_write_data,
    output logic [3:0]  periph_bus_byte_enable,
    output logic        periph_bus_write_req,
    output logic        periph_bus_read_req,
    input  logic [31:0] periph_bus_read_data,
    input  logic        periph_bus_read_data_valid
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] TGT_MEM = 2'b00;
    localparam logic [1:0] TGT_PER = 2'b01;
    localparam logic [1:0] TGT_UNM = 2'b10;

    logic [CW-1:0] r_count;
    logic [1:0]    r_cur_tgt;
    logic          r_unm_pend;

    logic [1:0]    w_tgt;
    logic          w_is_rd;
    logic          w_is_wr;
    logic          w_sel_rdy;
    logic          w_resp;
    logic [31:0]   w_resp_data;
    logic          w_full;
    logic          w_mismatch;
    logic          w_blocked;
    logic          w_acc_rd;

    assign w_tgt   = system_bus_addr[29] ? TGT_UNM : {1'b0, system_bus_addr[28]};
    assign w_is_wr = system_bus_write_req;
    assign w_is_rd = system_bus_read_req & ~system_bus_write_req;

    always_comb begin
        w_sel_rdy = 1'b1;
        case (w_tgt)
            TGT_MEM: w_sel_rdy = mem_bus_ready;
            TGT_PER: w_sel_rdy = periph_bus_ready;
            default: w_sel_rdy = 1'b1;
        endcase
    end

    // Only the current read target may answer, and only while something is outstanding.
    always_comb begin
        w_resp      = 1'b0;
        w_resp_data = 32'h0000_0000;
        if (!reset && r_count != '0) begin
            case (r_cur_tgt)
                TGT_MEM: begin
                    w_resp      = mem_bus_read_data_valid;
                    w_resp_data = mem_bus_read_data;
                end
                TGT_PER: begin
                    w_resp      = periph_bus_read_data_valid;
                    w_resp_data = periph_bus_read_data;
                end
                default: begin
                    w_resp      = r_unm_pend;
                    w_resp_data = 32'h0000_0000;
                end
            endcase
        end
        if (!w_resp) w_resp_data = 32'h0000_0000;
    end

    // A response retiring this cycle frees a slot, so a full queue can still take a read.
    assign w_full     = (r_count == CNT_MAX) & ~w_resp;
    assign w_mismatch = (r_count != '0) & (w_tgt != r_cur_tgt);
    assign w_blocked  = w_is_rd & (w_full | w_mismatch);

    assign system_bus_ready           = ~reset & w_sel_rdy & ~w_blocked;
    assign system_bus_read_data_valid = w_resp;
    assign system_bus_read_data       = w_resp_data;
    assign w_acc_rd                   = w_is_rd & system_bus_ready;

    assign mem_bus_addr           = system_bus_addr[27:0];
    assign mem_bus_write_data     = system_bus_write_data;
    assign mem_bus_byte_enable    = system_bus_byte_enable;
    assign periph_bus_addr        = system_bus_addr[27:0];
    assign periph_bus_write_data  = system_bus_write_data;
    assign periph_bus_byte_enable = system_bus_byte_enable;

    assign mem_bus_read_req     = ~reset & w_is_rd & (w_tgt == TGT_MEM) & ~w_blocked;
    assign mem_bus_write_req    = ~reset & w_is_wr & (w_tgt == TGT_MEM);
    assign periph_bus_read_req  = ~reset & w_is_rd & (w_tgt == TGT_PER) & ~w_blocked;
    assign periph_bus_write_req = ~reset & w_is_wr & (w_tgt == TGT_PER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_cur_tgt  <= TGT_MEM;
            r_unm_pend <= 1'b0;
        end else begin
            if (w_acc_rd) r_cur_tgt <= w_tgt;
            // Unmapped reads are answered exactly one cycle after acceptance.
            r_unm_pend <= w_acc_rd & (w_tgt == TGT_UNM);
            if (w_acc_rd && !w_resp) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_acc_rd && w_resp) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_system_bus_interconnect.sv
// Randomised and directed bench for system_bus_interconnect with a queue-based reference model.
module tb_system_bus_interconnect;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        system_bus_ready;
  logic [29:0] system_bus_addr = '0;
  logic [31:0] system_bus_write_data = '0;
  logic [3:0]  system_bus_byte_enable = '0;
  logic        system_bus_write_req = 1'b0;
  logic        system_bus_read_req = 1'b0;
  logic [31:0] system_bus_read_data;
  logic        system_bus_read_data_valid;
  logic        mem_bus_ready = 1'b0;
  logic [27:0] mem_bus_addr;
  logic [31:0] mem_bus_write_data;
  logic [3:0]  mem_bus_byte_enable;
  logic        mem_bus_write_req;
  logic        mem_bus_read_req;
  logic [31:0] mem_bus_read_data = '0;
  logic        mem_bus_read_data_valid = 1'b0;
  logic        periph_bus_ready = 1'b0;
  logic [27:0] periph_bus_addr;
  logic [31:0] periph_bus_write_data;
  logic [3:0]  periph_bus_byte_enable;
  logic        periph_bus_write_req;
  logic        periph_bus_read_req;
  logic [31:0] periph_bus_read_data = '0;
  logic        periph_bus_read_data_valid = 1'b0;

  always #5 clk = ~clk;

  system_bus_interconnect #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .system_bus_ready(system_bus_ready), .system_bus_addr(system_bus_addr),
    .system_bus_write_data(system_bus_write_data), .system_bus_byte_enable(system_bus_byte_enable),
    .system_bus_write_req(system_bus_write_req), .system_bus_read_req(system_bus_read_req),
    .system_bus_read_data(system_bus_read_data), .system_bus_read_data_valid(system_bus_read_data_valid),
    .mem_bus_ready(mem_bus_ready), .mem_bus_addr(mem_bus_addr),
    .mem_bus_write_data(mem_bus_write_data), .mem_bus_byte_enable(mem_bus_byte_enable),
    .mem_bus_write_req(mem_bus_write_req), .mem_bus_read_req(mem_bus_read_req),
    .mem_bus_read_data(mem_bus_read_data), .mem_bus_read_data_valid(mem_bus_read_data_valid),
    .periph_bus_ready(periph_bus_ready), .periph_bus_addr(periph_bus_addr),
    .periph_bus_write_data(periph_bus_write_data), .periph_bus_byte_enable(periph_bus_byte_enable),
    .periph_bus_write_req(periph_bus_write_req), .periph_bus_read_req(periph_bus_read_req),
    .periph_bus_read_data(periph_bus_read_data), .periph_bus_read_data_valid(periph_bus_read_data_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: expected read data in order, targets of outstanding reads (0 mem, 1 periph, 2 unmapped).
  logic [31:0] exp_q[$];
  int          out_q[$];
  bit          unm_next = 1'b0;

  // Behavioural slaves: in-order responses scheduled for a given cycle.
  logic [31:0] mq_data[$];
  int          mq_due[$];
  logic [31:0] pq_data[$];
  int          pq_due[$];
  int          m_last = 0;
  int          p_last = 0;

  int          fix_lat = 0;
  bit          rdy_force = 1'b0;
  bit          be_fix = 1'b0;
  logic [3:0]  be_val = 4'h0;

  function automatic int tgt_of(input logic [29:0] a);
    return a[29] ? 2 : int'(a[28]);
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, check and advance the model at negedge.
  task automatic step(input logic rst, input logic rd, input logic wr, input logic [29:0] a, output bit acc);
    int t;
    int lat;
    int due;
    bit is_rd;
    bit fwd;
    bit blk;
    bit sel;
    bit exp_rdy;
    logic [31:0] d;
    logic [5:0] got;
    logic [5:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    system_bus_read_req = rd;
    system_bus_write_req = wr;
    system_bus_addr = a;
    system_bus_write_data = $urandom;
    system_bus_byte_enable = be_fix ? be_val : 4'($urandom_range(0, 15));
    mem_bus_ready = rdy_force || ($urandom_range(0, 3) != 0);
    periph_bus_ready = rdy_force || ($urandom_range(0, 3) != 0);
    mem_bus_read_data_valid = 1'b0;
    mem_bus_read_data = $urandom;
    if (mq_due.size() != 0 && mq_due[0] == cyc) begin
      mem_bus_read_data_valid = 1'b1;
      mem_bus_read_data = mq_data.pop_front();
      void'(mq_due.pop_front());
    end
    periph_bus_read_data_valid = 1'b0;
    periph_bus_read_data = $urandom;
    if (pq_due.size() != 0 && pq_due[0] == cyc) begin
      periph_bus_read_data_valid = 1'b1;
      periph_bus_read_data = pq_data.pop_front();
      void'(pq_due.pop_front());
    end
    @(negedge clk);
    t = tgt_of(a);
    is_rd = rd && !wr;
    fwd = !rst && out_q.size() != 0 &&
          ((out_q[0] == 0 && mem_bus_read_data_valid) ||
           (out_q[0] == 1 && periph_bus_read_data_valid) ||
           (out_q[0] == 2 && unm_next));
    sel = (t == 2) || (t == 0 ? mem_bus_ready : periph_bus_ready);
    blk = is_rd && ((out_q.size() == MAX && !fwd) || (out_q.size() != 0 && out_q[0] != t));
    exp_rdy = !rst && sel && !blk;
    exp = {exp_rdy, !rst && is_rd && t == 0 && !blk, !rst && wr && t == 0,
           !rst && is_rd && t == 1 && !blk, !rst && wr && t == 1, fwd};
    got = {system_bus_ready, mem_bus_read_req, mem_bus_write_req,
           periph_bus_read_req, periph_bus_write_req, system_bus_read_data_valid};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ctl cyc=%0d {rdy,mrd,mwr,prd,pwr,vld}: got %b expected %b", cyc, got, exp);
    end
    n_vec++;
    if (mem_bus_addr !== a[27:0] || periph_bus_addr !== a[27:0] ||
        mem_bus_write_data !== system_bus_write_data || periph_bus_write_data !== system_bus_write_data ||
        mem_bus_byte_enable !== system_bus_byte_enable || periph_bus_byte_enable !== system_bus_byte_enable) begin
      n_err++;
      $display("FAIL fanout cyc=%0d: addr %h/%h be %h/%h expected addr %h be %h", cyc,
               mem_bus_addr, periph_bus_addr, mem_bus_byte_enable, periph_bus_byte_enable,
               a[27:0], system_bus_byte_enable);
    end
    acc = exp_rdy && (rd || wr);
    if (rst) begin
      out_q.delete();
      exp_q.delete();
      unm_next = 1'b0;
    end else begin
      if (fwd) void'(out_q.pop_front());
      unm_next = 1'b0;
      if (acc && is_rd) begin
        out_q.push_back(t);
        if (t == 2) begin
          exp_q.push_back(32'h0);
          unm_next = 1'b1;
        end else begin
          lat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 4);
          d = $urandom;
          exp_q.push_back(d);
          if (t == 0) begin
            due = cyc + lat;
            if (due <= m_last) due = m_last + 1;
            m_last = due;
            mq_data.push_back(d);
            mq_due.push_back(due);
          end else begin
            due = cyc + lat;
            if (due <= p_last) due = p_last + 1;
            p_last = due;
            pq_data.push_back(d);
            pq_due.push_back(due);
          end
        end
      end
    end
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [29:0] a, output int stalls);
    bit acc;
    stalls = 0;
    step(1'b0, rd, wr, a, acc);
    while (!acc && stalls < 50) begin
      stalls++;
      step(1'b0, rd, wr, a, acc);
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout addr=%h: got no acceptance expected acceptance", a);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mq_due.size() != 0 || pq_due.size() != 0) && n < 60) begin
      step(1'b0, 1'b0, 1'b0, 30'($urandom), acc);
      n++;
    end
    check_int("drain_pending_responses", exp_q.size(), 0);
  endtask

  // Monitor: every presented response is popped from the expected queue and compared.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    n_vec++;
    if (system_bus_read_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: got valid data %h expected no response", system_bus_read_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (system_bus_read_data !== exp_d) begin
          n_err++;
          $display("FAIL resp_data: got %h expected %h", system_bus_read_data, exp_d);
        end
      end
    end else if (system_bus_read_data !== 32'h0 || system_bus_read_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL resp_idle: got valid %b data %h expected 0/0",
               system_bus_read_data_valid, system_bus_read_data);
    end
  end

  initial begin
    bit acc;
    int st;
    logic [29:0] a;
    step(1'b1, 1'b1, 1'b0, 30'h0000_0010, acc);
    step(1'b1, 1'b0, 1'b1, 30'h1000_0000, acc);
    step(1'b1, 1'b1, 1'b0, 30'h2000_0000, acc);

    rdy_force = 1'b1;
    fix_lat = 2;
    xfer(1'b1, 1'b0, 30'h0000_0010, st);
    check_int("single_mem_read_stall", st, 0);
    drain();

    fix_lat = 6;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 30'(i * 4), st);
      check_int("b2b_read_stall", st, 0);
    end
    xfer(1'b1, 1'b0, 30'h0000_0100, st);
    check_int("fifth_read_stall", st, 2);
    drain();

    fix_lat = 3;
    xfer(1'b1, 1'b0, 30'h0000_0020, st);
    xfer(1'b1, 1'b0, 30'h1000_0004, st);
    check_int("cross_target_read_stall", st, 3);
    drain();

    xfer(1'b1, 1'b0, 30'h0000_0040, st);
    be_fix = 1'b1;
    be_val = 4'b0011;
    xfer(1'b0, 1'b1, 30'h1000_0008, st);
    check_int("periph_write_under_read_stall", st, 0);
    be_fix = 1'b0;
    drain();

    xfer(1'b1, 1'b0, 30'h2000_0000, st);
    check_int("unmapped_read_stall", st, 0);
    step(1'b0, 1'b0, 1'b0, 30'h0, acc);
    xfer(1'b0, 1'b1, 30'h2000_0000, st);
    check_int("unmapped_write_stall", st, 0);
    drain();

    fix_lat = 5;
    xfer(1'b1, 1'b0, 30'h0000_0050, st);
    xfer(1'b1, 1'b0, 30'h0000_0054, st);
    step(1'b1, 1'b0, 1'b0, 30'h0, acc);
    drain();
    fix_lat = 2;
    xfer(1'b1, 1'b0, 30'h0000_0080, st);
    check_int("post_reset_read_stall", st, 0);
    drain();

    rdy_force = 1'b0;
    fix_lat = 0;
    for (int i = 0; i < 600; i++) begin
      a = 30'($urandom);
      a[29:28] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(1'b0, $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0, a, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/system_bus_interconnect.md
SYSTEM_BUS_INTERCONNECT -- requirements
Module: system_bus_interconnect

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum accepted-but-unanswered reads (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have master ports from the CPU: system_bus_ready out 1; system_bus_addr in 30 (word address); system_bus_write_data in 32; system_bus_byte_enable in 4; system_bus_write_req in 1; system_bus_read_req in 1; system_bus_read_data out 32; system_bus_read_data_valid out 1.
REQ-005 SHALL have, for each slave prefix mem_ and periph_: <p>bus_ready in 1; <p>bus_addr out 28; <p>bus_write_data out 32; <p>bus_byte_enable out 4; <p>bus_write_req out 1; <p>bus_read_req out 1; <p>bus_read_data in 32; <p>bus_read_data_valid in 1.

Function
REQ-006 SHALL decode target from system_bus_addr[29:28]: 00 -> mem, 01 -> periph, 1x -> internal unmapped target.
REQ-007 SHALL drive both slaves' addr with system_bus_addr[27:0], plus write_data and byte_enable, unconditionally.
REQ-008 SHALL define a transfer as accepted on an edge where read_req or write_req is high and system_bus_ready is high; read_req and write_req both high SHALL be treated as a write only.
REQ-009 SHALL hold state: outstanding count (0..MAX_OUTSTANDING), current read target (2 bits), unmapped response pending flag.
REQ-010 SHALL block a read (ready low, no slave req) when count == MAX_OUTSTANDING, or when count != 0 and decoded target != current read target.
REQ-011 SHALL never block writes on outstanding reads; writes to any target proceed subject only to that target's ready.
REQ-012 SHALL drive system_bus_ready combinationally = selected target ready AND NOT blocked; unmapped target ready is always 1.
REQ-013 SHALL assert <p>bus_read_req/<p>bus_write_req only when the matching master req is high, target decodes to <p>, not blocked, and not in reset.
REQ-014 SHALL, on an accepted read, set current read target to the decoded target; count +1.
REQ-015 SHALL, on a returned response, count -1; accept and return in the same cycle leaves count unchanged.
REQ-016 SHALL pass system_bus_read_data/valid combinationally from the current read target's slave when count != 0; zero-cycle added latency.
REQ-017 SHALL drop (not forward, not decrement) any slave read_data_valid when count == 0 or the slave is not the current read target.
REQ-018 SHALL answer an accepted unmapped read exactly one cycle later with valid=1, data 32'h00000000; unmapped writes are accepted in one cycle and discarded.
REQ-019 SHALL drive system_bus_read_data to 0 whenever system_bus_read_data_valid is 0.
REQ-020 SHALL preserve response order equal to acceptance order (guaranteed by REQ-010).

Reset
REQ-021 SHALL, while reset is high: ready=0, all slave reqs=0, read_data_valid=0, read_data=0.
REQ-022 SHALL, on the edge with reset high, clear count to 0, current read target to mem, unmapped pending to 0.
REQ-023 SHALL drop slave responses to reads accepted before a reset mid-operation (covered by REQ-017).

Verification
REQ-024 Read addr 30'h0000_0010, mem_bus_ready=1, mem returns 32'h1234_5678 two cycles later -> mem_bus_read_req one cycle, mem_bus_addr 28'h10, master sees valid with 32'h1234_5678, count back to 0.
REQ-025 Four back-to-back mem reads, no responses, fifth read issued -> ready low on fifth until first response; fifth accepted the same cycle that response returns.
REQ-026 Mem read outstanding, then periph read (addr 30'h1000_0004) -> ready low, periph_bus_read_req 0, until mem response; then periph read accepted.
REQ-027 Mem read outstanding, then periph write byte_enable 4'b0011 -> periph_bus_write_req asserted, accepted immediately; mem response still delivered.
REQ-028 Read addr 30'h2000_0000 -> ready=1, no slave req, next cycle valid=1 data 0; write same addr -> accepted, no slave activity.
REQ-029 Two mem reads outstanding, assert reset one cycle, mem then returns two responses -> no valid to master, count 0, fresh read works normally.
